// File: rtl/fetch_queue_stage.sv
// Sequential instruction fetch stage: credit-limited request issue, in-order
// prefetch queue of {pc, inst}, and branch redirect with stale-response discard.
module fetch_queue_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] target_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              decode_valid,
    output logic [ADDR_W-1:0] decode_pc,
    output logic [INST_W-1:0] decode_inst,
    input  logic              decode_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [INST_W-1:0] r_fifo_inst [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     r_disc;
    logic              r_mem_req;

    logic              w_issue;
    logic              w_accept;
    logic              w_drop;
    logic              w_pop;
    logic              w_decode_valid;
    logic [CW-1:0]     w_cnt_nxt;
    logic [CW-1:0]     w_outst_nxt;
    logic [CW-1:0]     w_disc_nxt;
    logic [SW-1:0]     w_credit_sum;
    logic              w_mem_req_nxt;

    assign w_decode_valid = (r_cnt != {CW{1'b0}});
    assign mem_req        = r_mem_req;
    assign mem_addr       = r_pc;
    assign decode_valid   = w_decode_valid;
    assign decode_pc      = w_decode_valid ? r_fifo_pc[r_rd_ptr]   : {ADDR_W{1'b0}};
    assign decode_inst    = w_decode_valid ? r_fifo_inst[r_rd_ptr] : {INST_W{1'b0}};

    // Next-state counters; a redirect turns every request still in flight into a discard.
    always_comb begin
        w_issue  = r_mem_req & mem_gnt;
        w_accept = mem_rvalid & (r_disc == {CW{1'b0}});
        w_drop   = mem_rvalid & (r_disc != {CW{1'b0}});
        w_pop    = w_decode_valid & decode_ready;
        if (branch_taken) begin
            w_cnt_nxt   = {CW{1'b0}};
            w_outst_nxt = {CW{1'b0}};
            w_disc_nxt  = r_disc + r_outst + CW'(w_issue) - CW'(mem_rvalid);
        end else begin
            w_cnt_nxt   = r_cnt + CW'(w_accept) - CW'(w_pop);
            w_outst_nxt = r_outst + CW'(w_issue) - CW'(w_accept);
            w_disc_nxt  = r_disc - CW'(w_drop);
        end
        w_credit_sum  = SW'(w_cnt_nxt) + SW'(w_outst_nxt) + SW'(w_disc_nxt);
        w_mem_req_nxt = (w_credit_sum < SW'(DEPTH));
    end

    // Control state: pcs, pointers, occupancy/credit counters and the registered request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_wr_ptr  <= {PW{1'b0}};
            r_rd_ptr  <= {PW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_outst   <= {CW{1'b0}};
            r_disc    <= {CW{1'b0}};
            r_mem_req <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_outst   <= w_outst_nxt;
            r_disc    <= w_disc_nxt;
            r_mem_req <= w_mem_req_nxt;
            if (branch_taken) begin
                r_pc     <= target_pc;
                r_rsp_pc <= target_pc;
                r_wr_ptr <= {PW{1'b0}};
                r_rd_ptr <= {PW{1'b0}};
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + ADDR_W'(PC_STEP);
                end
                if (w_accept) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_W'(PC_STEP);
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // Queue storage; validity is carried by r_cnt, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !branch_taken) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_inst[r_wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised next-generation fetch stage that decouples PC generation from decode through an in-order prefetch queue.
- Issues sequential instruction requests to instruction memory over a req/gnt + rvalid interface with variable latency.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- On branch redirect, flushes the queue and discards responses still in flight.

Parameters:
- ADDR_W, 16: PC / memory address width.
- INST_W, 32: instruction width.
- DEPTH, 4: queue entries, also the limit on total requests in flight (power of two, ≥2).
- PC_STEP, 4: PC increment per sequential fetch.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- branch_taken  in  1  redirect request, single-cycle pulse.
- target_pc  in  ADDR_W  redirect address, sampled when branch_taken=1.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_W  fetch address, equal to the internal pc.
- mem_gnt  in  1  request accepted this cycle when mem_req=1.
- mem_rvalid  in  1  response data valid; responses return in request order.
- mem_rdata  in  INST_W  response instruction.
- decode_valid  out  1  queue head valid.
- decode_pc  out  ADDR_W  PC of queue head.
- decode_inst  out  INST_W  instruction of queue head.
- decode_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; queue count, outstanding and discard counters = 0.
  - mem_req=0, decode_valid=0, decode_pc=0, decode_inst=0.
  - Any in-flight responses are forgotten; memory must also be reset.
- State (counter widths clog2(DEPTH+1)):
  - pc.
  - FIFO of {pc, inst} with rd/wr pointers.
  - cnt: queue occupancy.
  - outst: live requests in flight.
  - disc: stale requests in flight.
- Credit rule:
  - mem_req = (cnt + outst + disc < DEPTH).
  - mem_req is driven from registers only; there is no combinational path from any input.
  - issue = mem_req & mem_gnt.
  - On issue: outst++, pc += PC_STEP (wraps modulo 2^ADDR_W).
- Response rule:
  - If mem_rvalid and disc>0: disc--, data dropped.
  - If mem_rvalid and disc==0: write {pc_tag, mem_rdata} into the FIFO and decrement outst.
  - pc_tag is tracked by a separate response-PC register advanced by PC_STEP per accepted response.
  - A written entry is visible at decode no earlier than the next cycle (1-cycle response-to-decode latency, no bypass).
- Decode handshake:
  - decode_valid = (cnt>0).
  - Pop when decode_valid & decode_ready.
  - Head outputs hold stable while decode_valid=1 and decode_ready=0.
- Push and pop in the same cycle: cnt unchanged. The queue never overflows; the credit rule guarantees this.
- Branch (branch_taken=1), applied at the next edge, with priority over normal updates:
  - pc and response-PC register <= target_pc.
  - cnt, pointers <= 0; any pop in that cycle is ignored.
  - disc <= disc + outst + issue - (mem_rvalid ? 1 : 0), where a response arriving in the branch cycle is dropped.
  - outst <= 0.
  - decode_valid=0 the cycle after the branch.
  - mem_req re-evaluates with the new counters; the first post-branch request uses target_pc.
- Back-to-back branches: the last one wins; discards accumulate correctly.
- Memory stall (mem_gnt=0): mem_req and mem_addr hold.
- Decode stall (decode_ready=0): the queue fills, then mem_req drops once credits are exhausted.

Test Plan:
- Reset, then 0-latency memory (gnt=1, rvalid the cycle after issue, rdata=addr), decode_ready=1 → decode_pc sequence 0,4,8,12…, one per cycle in steady state, decode_inst equals decode_pc.
- decode_ready=0 with DEPTH=4 → exactly 4 grants, mem_req=0 after the 4th; raise ready → decode sees 0,4,8,12 in order, then fetching resumes at 16.
- Memory latency 3, branch_taken with target_pc=0x100 while 2 requests are outstanding → both stale responses dropped; the next decode_valid entry has decode_pc=0x100.
- Branch in the same cycle as mem_rvalid and issue → both responses dropped (disc correct), the queue is empty next cycle, no stale PC reaches decode.
- pc=0xFFFC (ADDR_W=16), sequential fetch → next mem_addr=0x0000.
- Assert reset mid-stream with a full queue → all outputs at reset values immediately, before the next clk edge; after release, first mem_addr=RESET_PC.
